// File: rtl/sti_desc_sequencer.sv
// sti_desc_sequencer: fetches transmit descriptors from a synchronous RAM and
// presents them one word at a time on the STI parallel interface. Each word
// is paced by the STI's so_valid. pi_end is raised after the last descriptor.
// err is raised if the STI never starts shifting, or if the address space is
// exhausted before a descriptor marked last is seen.
module sti_desc_sequencer #(
  parameter int ADDR_W  = 8,   // descriptor RAM address width
  parameter int GAP_CYC = 2,   // idle cycles between so_valid falling and next fetch (0..15)
  parameter int TMO_CYC = 8    // cycles allowed from load falling to so_valid rising (1..255)
) (
  input  logic              clk,
  input  logic              reset,      // asynchronous, active-low
  input  logic              start,
  output logic              desc_rd,
  output logic [ADDR_W-1:0] desc_addr,
  input  logic [23:0]       desc_data,
  output logic              load,
  output logic [15:0]       pi_data,
  output logic [1:0]        pi_length,
  output logic              pi_fill,
  output logic              pi_msb,
  output logic              pi_low,
  output logic              pi_end,
  input  logic              so_valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_RDWAIT, S_LOAD, S_WAIT_ST, S_WAIT_DN, S_GAP, S_END, S_ERR
  } state_t;

  // Terminal counts of the shared cycle counter. A zero-length gap never
  // enters S_GAP, so its terminal value is never used in that case.
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);
  localparam logic [7:0] GAP_LAST = (GAP_CYC > 0) ? 8'(GAP_CYC - 1) : 8'd0;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_cnt;
  logic              r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_pi_data;
  logic [1:0]        r_pi_length;
  logic              r_pi_fill;
  logic              r_pi_msb;
  logic              r_pi_low;
  logic              r_pi_end;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W:0]   r_word_cnt;

  logic w_start_ok;
  logic w_word_done;
  logic w_decide;
  logic w_addr_max;
  logic w_overflow;
  logic w_advance;
  logic w_enter_end;
  logic w_unused_hi;

  // The two top descriptor bits carry no meaning for this block.
  assign w_unused_hi = ^desc_data[23:22];

  // A run may only be started from a resting state; start while busy is ignored.
  assign w_start_ok  = start && (r_state inside {S_IDLE, S_END, S_ERR});
  // The STI has finished shifting the current word.
  assign w_word_done = (r_state == S_WAIT_DN) && !so_valid;
  // Decision point after a word: end of the gap, or straight after the word with no gap.
  assign w_decide    = (GAP_CYC == 0) ? w_word_done
                                      : ((r_state == S_GAP) && (r_cnt == GAP_LAST));
  assign w_addr_max  = &r_addr;
  assign w_overflow  = w_decide && !r_last && w_addr_max;
  assign w_advance   = w_decide && !r_last && !w_addr_max;
  assign w_enter_end = (w_state_nxt == S_END) && (r_state != S_END);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and Moore strobes (desc_rd, load, busy).
  always_comb begin
    // NOTE: every signal gets a default first so no path can leave it unassigned (no latch).
    w_state_nxt = r_state;
    desc_rd     = 1'b0;
    load        = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      S_IDLE, S_END, S_ERR: begin
        if (start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        desc_rd     = 1'b1;
        busy        = 1'b1;
        w_state_nxt = S_RDWAIT;
      end
      S_RDWAIT: begin
        busy        = 1'b1;
        w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        load        = 1'b1;
        busy        = 1'b1;
        w_state_nxt = S_WAIT_ST;
      end
      S_WAIT_ST: begin
        busy = 1'b1;
        if (so_valid)               w_state_nxt = S_WAIT_DN;
        else if (r_cnt == TMO_LAST) w_state_nxt = S_ERR;
      end
      S_WAIT_DN: begin
        busy = 1'b1;
        if (!so_valid) begin
          if (GAP_CYC != 0)                w_state_nxt = S_GAP;
          else if (r_last || w_addr_max)   w_state_nxt = S_END;
          else                             w_state_nxt = S_FETCH;
        end
      end
      S_GAP: begin
        busy = 1'b1;
        if (w_decide) w_state_nxt = (r_last || w_addr_max) ? S_END : S_FETCH;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shared cycle counter: times the start-of-shift timeout and the inter-word gap,
  // restarting from zero on every state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 8'd0;
    end else if ((r_state == S_WAIT_ST || r_state == S_GAP) && (w_state_nxt == r_state)) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= 8'd0;
    end
  end

  // Descriptor address: cleared on start, advanced after each non-final word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_addr <= '0;
    else if (w_start_ok) r_addr <= '0;
    else if (w_advance)  r_addr <= r_addr + ADDR_W'(1);
  end

  // Capture the descriptor the cycle after the read strobe; held until the next capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pi_data   <= 16'd0;
      r_pi_length <= 2'd0;
      r_pi_fill   <= 1'b0;
      r_pi_msb    <= 1'b0;
      r_pi_low    <= 1'b0;
      r_last      <= 1'b0;
    end else if (r_state == S_RDWAIT) begin
      r_pi_data   <= desc_data[15:0];
      r_pi_length <= desc_data[17:16];
      r_pi_fill   <= desc_data[18];
      r_pi_msb    <= desc_data[19];
      r_pi_low    <= desc_data[20];
      r_last      <= desc_data[21];
    end
  end

  // Run status: end-of-stream flag, done pulse, sticky error and word counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pi_end   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_done <= w_enter_end;
      if (w_start_ok)       r_pi_end <= 1'b0;
      else if (w_enter_end) r_pi_end <= 1'b1;
      if (w_start_ok) r_err <= 1'b0;
      else if (((r_state == S_WAIT_ST) && (w_state_nxt == S_ERR)) || w_overflow) r_err <= 1'b1;
      if (w_start_ok) r_word_cnt <= '0;
      else if (w_word_done && !(&r_word_cnt)) r_word_cnt <= r_word_cnt + (ADDR_W+1)'(1);
    end
  end

  assign desc_addr = r_addr;
  assign pi_data   = r_pi_data;
  assign pi_length = r_pi_length;
  assign pi_fill   = r_pi_fill;
  assign pi_msb    = r_pi_msb;
  assign pi_low    = r_pi_low;
  assign pi_end    = r_pi_end;
  assign done      = r_done;
  assign err       = r_err;
  assign word_cnt  = r_word_cnt;

endmodule
